// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared types, y bit positions and the expected-value function for the gate checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    localparam int Y_AND  = 0;
    localparam int Y_OR   = 1;
    localparam int Y_NOT  = 2;
    localparam int Y_NAND = 3;
    localparam int Y_NOR  = 4;
    localparam int Y_XOR  = 5;
    localparam int Y_XNOR = 6;
    localparam int Y_W    = 7;

    function automatic logic [Y_W-1:0] expected_gates(input logic a, input logic b);
        logic [Y_W-1:0] e;
        e = '0;
        e[Y_AND]  = a & b;
        e[Y_OR]   = a | b;
        e[Y_NOT]  = ~a;
        e[Y_NAND] = ~(a & b);
        e[Y_NOR]  = ~(a | b);
        e[Y_XOR]  = a ^ b;
        e[Y_XNOR] = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/gate_vector_checker_ref.sv
// gate_ref_model: combinational expected outputs of the basic-gates block for the applied a/b.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic           a,
    input  logic           b,
    output logic [Y_W-1:0] exp_y
);

    assign exp_y = expected_gates(a, b);

endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: walks a/b through 00,01,10,11 holding each DWELL cycles,
// compares the gate outputs on the last cycle of each vector and reports the result.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [Y_W-1:0] y,
    output logic           a,
    output logic           b,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [3:0]     err_vec,
    output logic [2:0]     err_count
);

    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state;
    logic [1:0]       vec;
    logic [CNT_W-1:0] cnt;
    logic [Y_W-1:0]   exp_y;
    logic             cmp;
    logic             miss;
    logic [3:0]       err_nxt;

    gate_ref_model u_ref (.a(a), .b(b), .exp_y(exp_y));

    // err_nxt includes the current compare so pass sees the final vector's result.
    always_comb begin
        cmp     = (state == APPLY) && (cnt == LAST);
        miss    = cmp && (y != exp_y);
        err_nxt = miss ? (err_vec | (4'b0001 << vec)) : err_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_vec   <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= APPLY;
                    vec       <= '0;
                    cnt       <= '0;
                    a         <= 1'b0;
                    b         <= 1'b0;
                    busy      <= 1'b1;
                    pass      <= 1'b0;
                    err_vec   <= '0;
                    err_count <= '0;
                end
                APPLY: begin
                    cnt <= cnt + 1'b1;
                    if (miss) begin
                        err_vec   <= err_nxt;
                        err_count <= err_count + 3'd1;
                    end
                    if (cmp) begin
                        if (vec == 2'd3) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == 4'b0000);
                            a     <= 1'b0;
                            b     <= 1'b0;
                        end else begin
                            vec    <= vec + 2'd1;
                            cnt    <= '0;
                            {a, b} <= vec + 2'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
